// File: rtl/mem_2p_port_arb_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_2p_port_arb_if : client request/response and memory port bundle
// Revision: 1.0
// ------------------------------------------------------------------
interface mem_2p_port_arb_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 6,
  parameter int SEGS   = 1,
  parameter int SEGW   = 32
);
  localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int DW  = SEGS * SEGW;

  logic [NREQ-1:0]        rd_req;
  logic [NREQ*ADDR_W-1:0] rd_addr;
  logic [NREQ-1:0]        rd_gnt;
  logic                   rd_vld;
  logic [IDW-1:0]         rd_id;
  logic [DW-1:0]          rd_data;
  logic [NREQ-1:0]        wr_req;
  logic [NREQ*ADDR_W-1:0] wr_addr;
  logic [NREQ*SEGS-1:0]   wr_segwe;
  logic [NREQ*DW-1:0]     wr_data;
  logic [NREQ-1:0]        wr_gnt;
  logic                   mer;
  logic [ADDR_W-1:0]      raddr;
  logic [DW-1:0]          rdata;
  logic                   mew;
  logic [ADDR_W-1:0]      waddr;
  logic [SEGS-1:0]        segwe;
  logic [DW-1:0]          wdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_segwe, wr_data, rdata,
    output rd_gnt, rd_vld, rd_id, rd_data, wr_gnt,
    output mer, raddr, mew, waddr, segwe, wdata
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_segwe, wr_data, rdata,
    input  rd_gnt, rd_vld, rd_id, rd_data, wr_gnt,
    input  mer, raddr, mew, waddr, segwe, wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_2p_port_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_2p_port_arb : round-robin read/write arbiter for a 1R1W memory
// Revision: 1.0
// ------------------------------------------------------------------
module mem_2p_port_arb #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 6,
  parameter int SEGS   = 1,
  parameter int SEGW   = 32,
  parameter int RD_LAT = 1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mem_2p_port_arb_if.slave bus
);
  localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int DW  = SEGS * SEGW;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] req,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx[IDW-1:0]]) res = {1'b1, idx[IDW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] g);
    return (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
  endfunction

  logic [IDW-1:0]             rptr_q, rptr_d, wptr_q, wptr_d;
  logic [IDW:0]               w_rd_pick, w_wr_pick;
  logic [IDW-1:0]             w_rd_idx, w_wr_idx;
  logic [ADDR_W-1:0]          w_rd_addr, w_wr_addr;
  logic                       w_rd_sel, w_wr_sel, w_hazard;
  logic [RD_LAT-1:0]          vld_q;
  logic [RD_LAT-1:0][IDW-1:0] id_q;

  always_comb begin
    w_rd_pick = rr_pick(bus.rd_req, rptr_q);
    w_wr_pick = rr_pick(bus.wr_req, wptr_q);
    w_rd_idx  = w_rd_pick[IDW-1:0];
    w_wr_idx  = w_wr_pick[IDW-1:0];
    w_rd_addr = bus.rd_addr[w_rd_idx*ADDR_W +: ADDR_W];
    w_wr_addr = bus.wr_addr[w_wr_idx*ADDR_W +: ADDR_W];
    w_wr_sel  = rst_n & w_wr_pick[IDW];
    // A read colliding with the granted write waits; rptr holds so it retries.
    w_hazard  = w_wr_sel & (w_rd_addr == w_wr_addr);
    w_rd_sel  = rst_n & w_rd_pick[IDW] & ~w_hazard;
    rptr_d    = w_rd_sel ? ptr_next(w_rd_idx) : rptr_q;
    wptr_d    = w_wr_sel ? ptr_next(w_wr_idx) : wptr_q;
  end

  assign bus.rd_gnt  = w_rd_sel ? ({{(NREQ-1){1'b0}}, 1'b1} << w_rd_idx) : '0;
  assign bus.wr_gnt  = w_wr_sel ? ({{(NREQ-1){1'b0}}, 1'b1} << w_wr_idx) : '0;
  assign bus.mer     = w_rd_sel;
  assign bus.raddr   = w_rd_sel ? w_rd_addr : '0;
  assign bus.mew     = w_wr_sel;
  assign bus.waddr   = w_wr_sel ? w_wr_addr : '0;
  assign bus.segwe   = w_wr_sel ? bus.wr_segwe[w_wr_idx*SEGS +: SEGS] : '0;
  assign bus.wdata   = w_wr_sel ? bus.wr_data[w_wr_idx*DW +: DW] : '0;
  assign bus.rd_vld  = rst_n & vld_q[RD_LAT-1];
  assign bus.rd_id   = rst_n ? id_q[RD_LAT-1] : '0;
  assign bus.rd_data = bus.rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      vld_q  <= '0;
      id_q   <= '0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      vld_q[0] <= w_rd_sel;
      id_q[0]  <= w_rd_sel ? w_rd_idx : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_2p_port_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mem_2p_port_arb : directed and random checks against a queue model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_mem_2p_port_arb;
  localparam int NREQ   = 3;
  localparam int ADDR_W = 6;
  localparam int SEGS   = 2;
  localparam int SEGW   = 32;
  localparam int RD_LAT = 2;
  localparam int IDW    = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int DW     = SEGS * SEGW;
  localparam int NENT   = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_2p_port_arb_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .SEGS(SEGS), .SEGW(SEGW)) bus ();

  mem_2p_port_arb #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .SEGS(SEGS), .SEGW(SEGW), .RD_LAT(RD_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Memory stand-in: per-segment write enables, two-cycle registered read.
  logic [DW-1:0] mem [NENT];
  logic [DW-1:0] rd_s1, rd_s2;
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < NENT; a++) mem[a] <= '0;
      mem_init <= 1'b1;
    end else if (bus.mew) begin
      for (int s = 0; s < SEGS; s++)
        if (bus.segwe[s]) mem[bus.waddr][s*SEGW +: SEGW] <= bus.wdata[s*SEGW +: SEGW];
    end
    rd_s1 <= mem[bus.raddr];
    rd_s2 <= rd_s1;
  end
  assign bus.rdata = rd_s2;

  typedef struct { int due; int id; logic [DW-1:0] data; } resp_t;
  resp_t         rq[$];
  logic [DW-1:0] gold [NENT];
  int m_rptr, m_wptr, cyc, e_rg, e_wg;
  int vectors, miscompares;

  function automatic int rr(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [ADDR_W-1:0] rda(input int i);
    return bus.rd_addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] wra(input int i);
    return bus.wr_addr[i*ADDR_W +: ADDR_W];
  endfunction

  // Let inputs settle, predict this cycle from the model and compare every output.
  task automatic settle();
    logic [NREQ-1:0]   eg_r, eg_w;
    logic [ADDR_W-1:0] e_ra, e_wa;
    logic [SEGS-1:0]   e_se;
    logic [DW-1:0]     e_wd;
    logic              e_vld;
    resp_t             f;
    #2;
    e_wg = rst_n ? rr(bus.wr_req, m_wptr) : -1;
    e_rg = rst_n ? rr(bus.rd_req, m_rptr) : -1;
    if (e_rg >= 0 && e_wg >= 0 && rda(e_rg) == wra(e_wg)) e_rg = -1;
    eg_r = '0; eg_w = '0; e_ra = '0; e_wa = '0; e_se = '0; e_wd = '0;
    if (e_rg >= 0) begin eg_r[e_rg] = 1'b1; e_ra = rda(e_rg); end
    if (e_wg >= 0) begin
      eg_w[e_wg] = 1'b1;
      e_wa = wra(e_wg);
      e_se = bus.wr_segwe[e_wg*SEGS +: SEGS];
      e_wd = bus.wr_data[e_wg*DW +: DW];
    end
    vectors++; if (bus.rd_gnt !== eg_r) begin miscompares++; $display("FAIL rd_gnt cyc=%0d got=%b exp=%b", cyc, bus.rd_gnt, eg_r); end
    vectors++; if (bus.wr_gnt !== eg_w) begin miscompares++; $display("FAIL wr_gnt cyc=%0d got=%b exp=%b", cyc, bus.wr_gnt, eg_w); end
    vectors++; if (bus.mer !== (e_rg >= 0)) begin miscompares++; $display("FAIL mer cyc=%0d got=%b exp=%b", cyc, bus.mer, e_rg >= 0); end
    vectors++; if (bus.raddr !== e_ra) begin miscompares++; $display("FAIL raddr cyc=%0d got=%h exp=%h", cyc, bus.raddr, e_ra); end
    vectors++; if (bus.mew !== (e_wg >= 0)) begin miscompares++; $display("FAIL mew cyc=%0d got=%b exp=%b", cyc, bus.mew, e_wg >= 0); end
    vectors++; if (bus.waddr !== e_wa) begin miscompares++; $display("FAIL waddr cyc=%0d got=%h exp=%h", cyc, bus.waddr, e_wa); end
    vectors++; if (bus.segwe !== e_se) begin miscompares++; $display("FAIL segwe cyc=%0d got=%b exp=%b", cyc, bus.segwe, e_se); end
    vectors++; if (bus.wdata !== e_wd) begin miscompares++; $display("FAIL wdata cyc=%0d got=%h exp=%h", cyc, bus.wdata, e_wd); end
    e_vld = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      f = rq.pop_front();
      e_vld = rst_n;
    end
    vectors++; if (bus.rd_vld !== e_vld) begin miscompares++; $display("FAIL rd_vld cyc=%0d got=%b exp=%b", cyc, bus.rd_vld, e_vld); end
    if (e_vld) begin
      vectors++; if (bus.rd_id !== IDW'(f.id)) begin miscompares++; $display("FAIL rd_id cyc=%0d got=%0d exp=%0d", cyc, bus.rd_id, f.id); end
      vectors++; if (bus.rd_data !== f.data) begin miscompares++; $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, bus.rd_data, f.data); end
    end
    if (!rst_n) begin
      vectors++; if (bus.rd_id !== '0) begin miscompares++; $display("FAIL rd_id_rst cyc=%0d got=%0d exp=0", cyc, bus.rd_id); end
    end
  endtask

  task automatic advance();
    logic [DW-1:0] wd;
    logic [SEGS-1:0] se;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_rptr = 0; m_wptr = 0;
      rq.delete();
    end else begin
      if (e_rg >= 0) begin
        rq.push_back('{due: cyc + RD_LAT, id: e_rg, data: gold[rda(e_rg)]});
        m_rptr = (e_rg + 1) % NREQ;
      end
      if (e_wg >= 0) begin
        wd = bus.wr_data[e_wg*DW +: DW];
        se = bus.wr_segwe[e_wg*SEGS +: SEGS];
        for (int s = 0; s < SEGS; s++)
          if (se[s]) gold[wra(e_wg)][s*SEGW +: SEGW] = wd[s*SEGW +: SEGW];
        m_wptr = (e_wg + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    bus.rd_req = '0; bus.wr_req = '0;
    for (int i = 0; i < n; i++) begin settle(); advance(); end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; bus.rd_req = '0; bus.wr_req = '0;
    settle(); advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rd_req = '1; bus.wr_req = '1; bus.wr_segwe = '1; bus.wr_data = '1;
    for (int i = 0; i < NREQ; i++) begin
      bus.rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i + 1);
      bus.wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i + 32);
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++;
      if (bus.rd_gnt !== '0 || bus.wr_gnt !== '0 || bus.mer !== 1'b0 || bus.mew !== 1'b0 || bus.rd_vld !== 1'b0) begin
        miscompares++; $display("FAIL reset_outputs rd_gnt=%b wr_gnt=%b mer=%b mew=%b rd_vld=%b exp all 0", bus.rd_gnt, bus.wr_gnt, bus.mer, bus.mew, bus.rd_vld);
      end
      advance();
    end
    rst_n = 1'b1;
    settle();
    vectors++;
    if (bus.rd_gnt !== 3'b001 || bus.wr_gnt !== 3'b001) begin
      miscompares++; $display("FAIL first_grant rd_gnt=%b wr_gnt=%b exp 001/001", bus.rd_gnt, bus.wr_gnt);
    end
    advance();
    idle_cycles(RD_LAT + 1);
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] eg;
    pulse_reset();
    bus.wr_req = '0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_req = '1;
      settle();
      eg = '0; eg[i % NREQ] = 1'b1;
      vectors++; if (bus.rd_gnt !== eg) begin miscompares++; $display("FAIL rr_order step=%0d got=%b exp=%b", i, bus.rd_gnt, eg); end
      if (i >= RD_LAT) begin
        vectors++;
        if (bus.rd_vld !== 1'b1 || bus.rd_id !== IDW'((i - RD_LAT) % NREQ)) begin
          miscompares++; $display("FAIL rr_resp step=%0d vld=%b id=%0d exp vld=1 id=%0d", i, bus.rd_vld, bus.rd_id, (i - RD_LAT) % NREQ);
        end
      end
      advance();
    end
    idle_cycles(RD_LAT + 1);
  endtask

  task automatic test_wrap_skip();
    pulse_reset();
    bus.wr_req = '0;
    bus.rd_req = 3'b010; settle(); advance();
    bus.rd_req = 3'b011; settle();
    vectors++; if (bus.rd_gnt !== 3'b001) begin miscompares++; $display("FAIL wrap_grant got=%b exp=001", bus.rd_gnt); end
    advance();
    bus.rd_req = 3'b111; settle();
    vectors++; if (bus.rd_gnt !== 3'b010) begin miscompares++; $display("FAIL wrap_ptr got=%b exp=010", bus.rd_gnt); end
    advance();
    idle_cycles(RD_LAT + 1);
  endtask

  task automatic test_hazard();
    logic [DW-1:0] wd;
    wd = {$urandom, $urandom};
    bus.wr_req = 3'b010; bus.wr_addr[1*ADDR_W +: ADDR_W] = 6'h15;
    bus.wr_segwe[1*SEGS +: SEGS] = 2'b11; bus.wr_data[1*DW +: DW] = wd;
    bus.rd_req = 3'b100; bus.rd_addr[2*ADDR_W +: ADDR_W] = 6'h15;
    settle();
    vectors++;
    if (bus.wr_gnt !== 3'b010 || bus.rd_gnt !== 3'b000 || bus.mer !== 1'b0) begin
      miscompares++; $display("FAIL hazard_block wr_gnt=%b rd_gnt=%b mer=%b exp 010/000/0", bus.wr_gnt, bus.rd_gnt, bus.mer);
    end
    advance();
    bus.wr_req = '0;
    settle();
    vectors++;
    if (bus.rd_gnt !== 3'b100 || bus.raddr !== 6'h15) begin
      miscompares++; $display("FAIL hazard_retry rd_gnt=%b raddr=%h exp 100/15", bus.rd_gnt, bus.raddr);
    end
    advance();
    bus.rd_req = '0;
    settle(); advance();
    settle();
    vectors++;
    if (bus.rd_vld !== 1'b1 || bus.rd_id !== IDW'(2) || bus.rd_data !== wd) begin
      miscompares++; $display("FAIL hazard_data vld=%b id=%0d data=%h exp 1/2/%h", bus.rd_vld, bus.rd_id, bus.rd_data, wd);
    end
    advance();
  endtask

  task automatic test_write_read();
    bus.rd_req = '0;
    bus.wr_req = 3'b001; bus.wr_addr[0 +: ADDR_W] = 6'h3F;
    bus.wr_segwe[0 +: SEGS] = 2'b11; bus.wr_data[0 +: DW] = 64'hCAFEF00D_12345678;
    settle(); advance();
    bus.wr_segwe[0 +: SEGS] = 2'b01; bus.wr_data[0 +: DW] = 64'hFFFFFFFF_DEADBEEF;
    settle(); advance();
    bus.wr_req = '0;
    bus.rd_req = 3'b001; bus.rd_addr[0 +: ADDR_W] = 6'h3F;
    settle(); advance();
    bus.rd_req = '0;
    settle(); advance();
    settle();
    vectors++;
    if (bus.rd_vld !== 1'b1 || bus.rd_data !== 64'hCAFEF00D_DEADBEEF) begin
      miscompares++; $display("FAIL seg_write vld=%b data=%h exp 1/cafef00ddeadbeef", bus.rd_vld, bus.rd_data);
    end
    advance();
  endtask

  task automatic test_reset_midflight();
    bus.wr_req = '0;
    bus.rd_req = 3'b001; settle(); advance();
    rst_n = 1'b0; bus.rd_req = '0; settle(); advance();
    rst_n = 1'b1; settle();
    vectors++; if (bus.rd_vld !== 1'b0) begin miscompares++; $display("FAIL midflight_flush got vld=%b exp=0", bus.rd_vld); end
    advance();
    idle_cycles(RD_LAT);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      bus.rd_req = NREQ'($urandom);
      bus.wr_req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        bus.rd_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 3));
        bus.wr_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 3));
        bus.wr_segwe[i*SEGS +: SEGS]     = SEGS'($urandom);
        bus.wr_data[i*DW +: DW]          = {$urandom, $urandom};
      end
      settle(); advance();
    end
    rst_n = 1'b1;
    idle_cycles(RD_LAT + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    m_rptr = 0; m_wptr = 0; e_rg = -1; e_wg = -1;
    for (int a = 0; a < NENT; a++) gold[a] = '0;
    bus.rd_req = '0; bus.wr_req = '0; bus.rd_addr = '0;
    bus.wr_addr = '0; bus.wr_segwe = '0; bus.wr_data = '0;
    test_reset();
    test_fairness();
    test_wrap_skip();
    test_hazard();
    test_write_read();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_2p_port_arb.md
# mem_2p_port_arb

Round-robin arbiter and response router that shares the two ports of one `cfg_2p_1r1w_mem` instance between `NREQ` requesters. It provides independent read and write arbitration and drives the memory's read and write ports directly. A write-over-read address hazard guard blocks a read from the same address as a same-cycle write. Read responses are returned after the memory's fixed read latency, tagged with the requester ID. The block sits between the compute-side clients and a single shared memory bank.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16
- `ADDR_W`, 6: memory address width; must equal the memory's full address width
- `SEGS`, 1: segments per entry
- `SEGW`, 32: bits per segment
- `RD_LAT`, 1: memory read latency in cycles, 1..2. Use 1 for memory RDTYPE 1 or 2, and 2 for RDTYPE 3.
- `IDW` (localparam): `max(1, $clog2(NREQ))`

Ports:
- `clk`  in  1  clock. One clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low
- `rd_req`  in  NREQ  per-requester read request, held until granted
- `rd_addr`  in  NREQ*ADDR_W  flattened read addresses; requester i at `[i*ADDR_W +: ADDR_W]`
- `rd_gnt`  out  NREQ  one-hot read grant (combinational)
- `rd_vld`  out  1  read response valid
- `rd_id`  out  IDW  requester index of the response
- `rd_data`  out  SEGS*SEGW  response data
- `wr_req`  in  NREQ  per-requester write request, held until granted
- `wr_addr`  in  NREQ*ADDR_W  flattened write addresses
- `wr_segwe`  in  NREQ*SEGS  flattened segment write enables
- `wr_data`  in  NREQ*SEGS*SEGW  flattened write data
- `wr_gnt`  out  NREQ  one-hot write grant (combinational)
- `mer`, `raddr`  out  1, ADDR_W  memory read port
- `rdata`  in  SEGS*SEGW  memory read data
- `mew`, `waddr`, `segwe`, `wdata`  out  1, ADDR_W, SEGS, SEGS*SEGW  memory write port

## Operation
- Two independent round-robin arbiters (read, write), each with a pointer register `rptr`/`wptr` (IDW bits).
- Reset value of both pointers is 0.
- Grant rule: the lowest index i ≥ ptr with req[i] set wins; if none, wrap and search from 0. At most one grant per port per cycle.
- Pointer update: on a grant to index g, ptr <= (g+1) mod NREQ, including the non-power-of-2 wrap. With no grant, the pointer holds.
- Write port: `mew = |wr_gnt`. `waddr`, `segwe` and `wdata` are muxed from the granted requester. When there is no grant, all four outputs are 0.
- Read port: `mer = |rd_gnt`. `raddr` is muxed from the granted requester, and is 0 when there is no grant.
- Hazard: suppose the read winner's address equals the current write winner's address. Then:
  - the read grant is suppressed that cycle;
  - `rptr` holds, so the same winner retries next cycle;
  - the write proceeds.
- Read data after a same-cycle write to a different address is unaffected.
- Response pipeline: a shift register RD_LAT deep of {valid, id}, reset to all 0. Stage 0 loads {`mer`, granted index}.
- `rd_vld` and `rd_id` are the last stage. `rd_data` is `rdata` passed through combinationally.
- No response backpressure; requesters must accept `rd_vld` unconditionally.
- Reset mid-operation:
  - in-flight responses are discarded (valid bits cleared);
  - pointers return to 0;
  - grants are forced to 0 while `rst_n` is low.

## Timing
- Request to grant: 0 cycles. A grant is combinational from `*_req`, the registered pointer, and (for reads) the hazard compare.
- Grant to memory: 0 cycles. Memory port signals are combinational from grants.
- Read grant in cycle N: `rd_vld` is high in cycle N+RD_LAT for exactly one cycle, with `rd_id` equal to the granted index.
- Throughput: one read grant plus one write grant per cycle. Back-to-back reads give back-to-back responses in grant order.
- Write commit: the memory entry updates at the edge ending the grant cycle. A read granted in the following cycle returns the new data.
- Outputs during and immediately after reset:
  - `rd_vld` = 0 and `rd_id` = 0;
  - `rd_gnt`, `wr_gnt`, `mer` and `mew` = 0;
  - `raddr`, `waddr`, `segwe` and `wdata` = 0.
- A requester deasserting `*_req` before its grant is legal; no state changes result.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with all requests high → all grants 0, `mer` = `mew` = 0, `rd_vld` = 0. On release, the first grant goes to index 0.
- Round-robin fairness: NREQ = 4, `rd_req` = 4'b1111 held for 8 cycles → grants go to 0, 1, 2, 3, 0, 1, 2, 3. With RD_LAT = 2, `rd_id` follows the same order offset by 2 cycles.
- Wrap and skip: NREQ = 3, `rptr` = 2, `rd_req` = 3'b011 → grant to index 0; `rptr` becomes 1.
- Hazard: write requester 1 and read requester 2 both at address 0x15 in the same cycle → write granted and read blocked. Next cycle the read is granted and returns the newly written data at RD_LAT.
- Write-then-read integrity: write 0xDEADBEEF to address 0x3F with `segwe` = 1, then read it → `rd_data` = 0xDEADBEEF. With SEGS = 2 and `segwe` = 2'b01, only the low segment changes.
- Reset mid-flight: read granted in cycle N with RD_LAT = 2, `rst_n` low in cycle N+1 → no `rd_vld` in cycle N+2.
